// File: rtl/writeback_queue_if.sv
// Writeback request / register-file write bundle for writeback_queue.
// Producer and forwarding-lookup signals share one interface.
interface writeback_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                       iMemValid;
    logic [ADDR_WIDTH-1:0]      iMemAddr;
    logic [DATA_WIDTH-1:0]      iMemData;
    logic                       iAluValid;
    logic [ADDR_WIDTH-1:0]      iAluAddr;
    logic [DATA_WIDTH-1:0]      iAluData;
    logic                       oWriteEnable;
    logic [ADDR_WIDTH-1:0]      oWriteAddress;
    logic [DATA_WIDTH-1:0]      oWriteData;
    logic                       oStall;
    logic                       oOverflow;
    logic [2**ADDR_WIDTH-1:0]   oPending;
    logic [ADDR_WIDTH-1:0]      iQueryAddr;
    logic                       oQueryHit;
    logic [DATA_WIDTH-1:0]      oQueryData;

    modport master (
        output iMemValid, iMemAddr, iMemData,
        output iAluValid, iAluAddr, iAluData,
        output iQueryAddr,
        input  oWriteEnable, oWriteAddress, oWriteData,
        input  oStall, oOverflow, oPending,
        input  oQueryHit, oQueryData
    );

    modport slave (
        input  iMemValid, iMemAddr, iMemData,
        input  iAluValid, iAluAddr, iAluData,
        input  iQueryAddr,
        output oWriteEnable, oWriteAddress, oWriteData,
        output oStall, oOverflow, oPending,
        output oQueryHit, oQueryData
    );
endinterface

// File: rtl/writeback_queue.sv
// Circular writeback FIFO draining one register-file write per cycle,
// with pending-register scoreboard and youngest-entry forwarding lookup.
module writeback_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input logic              Clock,
    input logic              Reset,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow;

    logic          pop;
    logic          mem_ok;
    logic          alu_ok;
    logic          acc_mem;
    logic          acc_alu;
    logic          drop;
    logic [CW-1:0] space;
    logic [PW-1:0] alu_slot;

    // The slot freed by this edge's pop is reusable on the same edge.
    always_comb begin
        pop      = (count != '0);
        mem_ok   = bus.iMemValid && (bus.iMemAddr != '0);
        alu_ok   = bus.iAluValid && (bus.iAluAddr != '0);
        space    = FULL - count + CW'(pop);
        acc_mem  = mem_ok && (space != '0);
        acc_alu  = alu_ok && (space > (acc_mem ? CW'(1) : CW'(0)));
        drop     = (mem_ok && !acc_mem) || (alu_ok && !acc_alu);
        alu_slot = tail + PW'(acc_mem);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(acc_mem) + PW'(acc_alu);
            count <= count - CW'(pop) + CW'(acc_mem) + CW'(acc_alu);
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Storage is never cleared; every read below is gated by count.
    always_ff @(posedge Clock) begin
        if (acc_mem) begin
            addr_q[tail] <= bus.iMemAddr;
            data_q[tail] <= bus.iMemData;
        end
        if (acc_alu) begin
            addr_q[alu_slot] <= bus.iAluAddr;
            data_q[alu_slot] <= bus.iAluData;
        end
    end

    logic [2**ADDR_WIDTH-1:0] pending;
    logic                     hit;
    logic [DATA_WIDTH-1:0]    qdata;
    logic [PW-1:0]            idx;

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        pending = '0;
        hit     = 1'b0;
        qdata   = '0;
        idx     = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx = head + PW'(j);
            if (CW'(j) < count) begin
                pending[addr_q[idx]] = 1'b1;
                if ((bus.iQueryAddr != '0) &&
                    (addr_q[idx] == bus.iQueryAddr)) begin
                    hit   = 1'b1;
                    qdata = data_q[idx];
                end
            end
        end
        pending[0] = 1'b0;
    end

    assign bus.oWriteEnable  = pop;
    assign bus.oWriteAddress = pop ? addr_q[head] : '0;
    assign bus.oWriteData    = pop ? data_q[head] : '0;
    assign bus.oStall        = (count >= FULL - CW'(1));
    assign bus.oOverflow     = overflow;
    assign bus.oPending      = pending;
    assign bus.oQueryHit     = hit;
    assign bus.oQueryData    = qdata;
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a
// queue-based reference model of the writeback rules.
module tb_writeback_queue;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ent_t q[$];
    logic m_ovf;

    writeback_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    writeback_queue #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [AW-1:0] ma,
                         input logic [DW-1:0] md, input logic av,
                         input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic [AW-1:0] qa);
        bus.iMemValid  = mv;
        bus.iMemAddr   = ma;
        bus.iMemData   = md;
        bus.iAluValid  = av;
        bus.iAluAddr   = aa;
        bus.iAluData   = ad;
        bus.iQueryAddr = qa;
    endtask

    task automatic compare();
        logic [2**AW-1:0] pend;
        logic             hit;
        logic [DW-1:0]    qd;
        pend = '0;
        hit  = 1'b0;
        qd   = '0;
        foreach (q[i]) pend[q[i].a] = 1'b1;
        pend[0] = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && bus.iQueryAddr != 0 && q[i].a == bus.iQueryAddr) begin
                hit = 1'b1;
                qd  = q[i].d;
            end
        end
        chk("we", bus.oWriteEnable, q.size() != 0);
        chk("waddr", bus.oWriteAddress, q.size() != 0 ? q[0].a : '0);
        chk("wdata", bus.oWriteData, q.size() != 0 ? q[0].d : '0);
        chk("stall", bus.oStall, q.size() >= DEPTH - 1);
        chk("ovf", bus.oOverflow, m_ovf);
        chk("pending", bus.oPending, pend);
        chk("qhit", bus.oQueryHit, hit);
        chk("qdata", bus.oQueryData, qd);
    endtask

    task automatic model_edge(input logic mv, input logic [AW-1:0] ma,
                              input logic [DW-1:0] md, input logic av,
                              input logic [AW-1:0] aa,
                              input logic [DW-1:0] ad);
        int   free;
        ent_t e;
        free = DEPTH - q.size();
        if (q.size() != 0) begin
            void'(q.pop_front());
            free++;
        end
        if (mv && ma != 0) begin
            if (free > 0) begin
                e.a = ma;
                e.d = md;
                q.push_back(e);
                free--;
            end else m_ovf = 1'b1;
        end
        if (av && aa != 0) begin
            if (free > 0) begin
                e.a = aa;
                e.d = ad;
                q.push_back(e);
            end else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic mv, input logic [AW-1:0] ma,
                        input logic [DW-1:0] md, input logic av,
                        input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic [AW-1:0] qa);
        drive(mv, ma, md, av, aa, ad, qa);
        #1;
        compare();
        @(posedge clk);
        model_edge(mv, ma, md, av, aa, ad);
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] qa);
        step(0, '0, '0, 0, '0, '0, qa);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;
        rst    = 1'b1;
        drive(0, '0, '0, 0, '0, '0, '0);
        #1;
        compare();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single request
        step(0, '0, '0, 1, 5'd3, 32'h1234, 5'd3);
        drive(0, '0, '0, 0, '0, '0, 5'd3);
        #1;
        chk("single_we", bus.oWriteEnable, 1);
        chk("single_addr", bus.oWriteAddress, 3);
        chk("single_data", bus.oWriteData, 32'h1234);
        idle(5'd3);
        chk("single_done", bus.oWriteEnable, 0);
        idle('0);

        // dual push to the same register
        step(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB, 5'd5);
        drive(0, '0, '0, 0, '0, '0, 5'd5);
        #1;
        chk("dual_qdata", bus.oQueryData, 32'hBB);
        chk("dual_pend", bus.oPending[5], 1);
        chk("dual_w1", bus.oWriteData, 32'hAA);
        idle(5'd5);
        chk("dual_w2", bus.oWriteData, 32'hBB);
        chk("dual_pend2", bus.oPending[5], 1);
        idle(5'd5);
        chk("dual_pend3", bus.oPending[5], 0);

        // zero address discarded
        step(0, '0, '0, 1, 5'd0, 32'hDEAD, '0);
        chk("zero_we", bus.oWriteEnable, 0);
        chk("zero_ovf", bus.oOverflow, 0);

        // fill while ignoring stall
        for (int i = 0; i < 5; i++)
            step(1, AW'(i + 1), 32'h100 + i, 1, AW'(i + 9), 32'h200 + i,
                 AW'(i + 1));
        chk("fill_ovf", bus.oOverflow, 1);
        for (int i = 0; i < 6; i++) idle(AW'(i + 9));
        chk("fill_sticky", bus.oOverflow, 1);

        // wrap-around
        for (int i = 1; i <= 10; i++)
            step(1, AW'(i), 32'h3000 + i, 0, '0, '0, AW'(i));
        idle('0);
        chk("wrap_empty", bus.oWriteEnable, 0);

        // reset mid-drain
        step(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 5'd7);
        step(1, 5'd9, 32'h99, 1, 5'd10, 32'hA0, 5'd8);
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk("rst_we", bus.oWriteEnable, 0);
        chk("rst_ovf", bus.oOverflow, 0);
        chk("rst_pend", bus.oPending, 0);
        chk("rst_hit", bus.oQueryHit, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(5'd9);

        // randomized traffic with duplicates and zero addresses
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)),
                 $urandom,
                 $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)),
                 $urandom,
                 AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(AW'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 The block SHALL have port Clock  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have ports iMemValid / iMemAddr / iMemData  input  1 / ADDR_WIDTH / DATA_WIDTH  load-result writeback request.
REQ-007 The block SHALL have ports iAluValid / iAluAddr / iAluData  input  1 / ADDR_WIDTH / DATA_WIDTH  ALU-result writeback request.
REQ-008 The block SHALL have ports oWriteEnable / oWriteAddress / oWriteData  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port drive.
REQ-009 The block SHALL have port oStall  output  1  producers must hold off new requests.
REQ-010 The block SHALL have port oOverflow  output  1  sticky: a request was dropped.
REQ-011 The block SHALL have port oPending  output  2**ADDR_WIDTH  bit k set while any queued entry targets register k.
REQ-012 The block SHALL have ports iQueryAddr  input  ADDR_WIDTH and oQueryHit  output  1 and oQueryData  output  DATA_WIDTH  forwarding lookup.

Function
REQ-013 Queue SHALL be a circular FIFO of DEPTH entries {addr, data}, with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-014 oWriteEnable SHALL equal (count != 0); oWriteAddress/oWriteData SHALL be head-entry fields, and 0 when empty.
REQ-015 When count != 0, head SHALL be popped on every rising edge (register file accepts one write per cycle, no backpressure).
REQ-016 Requests with valid=1 and addr=0 SHALL be discarded silently: not enqueued, not counted as overflow.
REQ-017 Push order within one cycle SHALL be Mem entry first (older), then Alu entry.
REQ-018 Accepted pushes SHALL satisfy count - pop + pushes <= DEPTH; Mem SHALL be accepted before Alu if only one slot is free.
REQ-019 Any request not accepted under REQ-018 SHALL be dropped and SHALL set oOverflow on that edge.
REQ-020 oStall SHALL be combinational: 1 when count >= DEPTH-1.
REQ-021 Latency: a request accepted at edge N SHALL appear on the write port after edge N if the queue was empty, otherwise after all older entries drain.
REQ-022 oPending[k] SHALL be combinational OR over valid entries with addr==k; oPending[0] SHALL be 0.
REQ-023 oQueryHit SHALL be 1 when any valid entry matches iQueryAddr (non-zero); oQueryData SHALL be the youngest matching entry's data, else 0.
REQ-024 Duplicate addresses in the queue SHALL be kept and written in order; the final register value SHALL be the youngest.
REQ-025 Simultaneous pop and pushes on a full queue (count=DEPTH) SHALL accept one push (Mem priority) and keep count=DEPTH.

Reset
REQ-026 Reset=1 SHALL immediately clear count, head, tail, oOverflow; oWriteEnable, oWriteAddress, oWriteData, oStall, oPending, oQueryHit, oQueryData SHALL read 0.
REQ-027 Reset asserted mid-drain SHALL abandon all queued entries; no write SHALL issue until a new request is accepted after release.
REQ-028 Entry storage contents need not be cleared; outputs SHALL be gated by count.

Verification
REQ-029 Single request: iAluValid=1, addr=3, data=0x1234 one cycle on empty queue -> next cycle oWriteEnable=1, addr=3, data=0x1234; following cycle oWriteEnable=0.
REQ-030 Dual push: Mem(5,0xAA) and Alu(5,0xBB) same edge -> writes 5<-0xAA then 5<-0xBB on consecutive cycles; oQueryHit for addr 5 returns 0xBB while both queued; oPending[5]=1 until second write.
REQ-031 Zero address: iAluValid=1, addr=0 -> no write, count unchanged, oOverflow=0.
REQ-032 Fill: both producers valid every cycle, DEPTH=4 -> oStall asserts at count=3; ignoring stall gives dropped Alu entry, oOverflow=1 sticky, writes remain in order with no loss of accepted entries.
REQ-033 Wrap-around: 10 sequential single pushes addr 1..10 -> 10 writes in order, pointers wrap twice, count returns to 0.
REQ-034 Reset mid-operation: 3 entries queued, assert Reset between edges -> outputs 0 immediately; after release oWriteEnable stays 0 until next request.
